// File: rtl/maindec_pkg.sv
// Shared types and encodings for the multicycle RV32I main decoder.
// MAINDEC_UPIMM_EN (see multicycle_maindec) enables the LUI/AUIPC states listed here.
package maindec_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRLINK, LUI, AUIPC, FAULT
    } statetype_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       adrsrc;
        logic       irwrite;
        logic       pcupdate;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [2:0] immsrc;
        logic [1:0] aluop;
        logic       fault;
    } maindec_ctl_t;

    function automatic logic [2:0] imm_for_op(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_maindec_timeout.sv
// Wait-state counter for memory requests; flags the cycle on which the
// MEM_TIMEOUT-th consecutive wait occurs (MEM_TIMEOUT=0 never expires).
module mem_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_cycle,
    output logic expire
);
    localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [TO_W-1:0] count;

    // Any non-wait cycle (idle or completed access) leaves the count at zero
    // for the next request.
    always_ff @(posedge clk) begin
        if (rst || !wait_cycle)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign expire = (MEM_TIMEOUT > 0) && wait_cycle &&
                    (count == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_maindec.sv
// Moore control FSM sequencing RV32I instructions over a shared memory/ALU datapath.
// Define MAINDEC_UPIMM_EN to add LUI/AUIPC; otherwise those opcodes decode as NOP.
module multicycle_maindec
    import maindec_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_adrsrc,
    output logic       o_irwrite,
    output logic       o_pcupdate,
    output logic       o_branch,
    output logic       o_memwrite,
    output logic       o_regwrite,
    output logic [1:0] o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_resultsrc,
    output logic [2:0] o_immsrc,
    output logic [1:0] o_aluop,
    output logic       o_fault
);
    statetype_e   state, state_next;
    maindec_ctl_t ctl;
    logic         mem_state, wait_cycle, expire;

    assign mem_state  = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign wait_cycle = mem_state && !i_mem_ready;

    mem_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk        (i_clk),
        .rst        (i_rst),
        .wait_cycle (wait_cycle),
        .expire     (expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        ctl        = '0;
        state_next = state;
        case (state)
            FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.alusrcb   = SRCB_FOUR;
                ctl.resultsrc = RES_ALU;
                ctl.irwrite   = i_mem_ready;
                ctl.pcupdate  = i_mem_ready;
                if (i_mem_ready) state_next = DECODE;
            end
            DECODE: begin
                ctl.alusrca = SRCA_OLDPC;
                ctl.alusrcb = SRCB_IMM;
                ctl.immsrc  = imm_for_op(i_op);
                case (i_op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
`ifdef MAINDEC_UPIMM_EN
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = AUIPC;
`endif
                    default:           state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ctl.alusrca = SRCA_RS1;
                ctl.alusrcb = SRCB_IMM;
                ctl.immsrc  = imm_for_op(i_op);
                state_next  = (i_op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctl.mem_req   = 1'b1;
                ctl.adrsrc    = 1'b1;
                ctl.resultsrc = RES_ALUOUT;
                if (i_mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                ctl.resultsrc = RES_DATA;
                ctl.regwrite  = 1'b1;
                state_next    = FETCH;
            end
            MEMWRITE: begin
                ctl.mem_req  = 1'b1;
                ctl.adrsrc   = 1'b1;
                ctl.memwrite = i_mem_ready;
                if (i_mem_ready) state_next = FETCH;
            end
            EXECR: begin
                ctl.alusrca = SRCA_RS1;
                ctl.alusrcb = SRCB_RS2;
                ctl.aluop   = ALUOP_FUNCT;
                state_next  = ALUWB;
            end
            EXECI: begin
                ctl.alusrca = SRCA_RS1;
                ctl.alusrcb = SRCB_IMM;
                ctl.immsrc  = IMM_I;
                ctl.aluop   = ALUOP_FUNCT;
                state_next  = ALUWB;
            end
            ALUWB, JALRLINK: begin
                ctl.resultsrc = RES_ALUOUT;
                ctl.regwrite  = 1'b1;
                state_next    = FETCH;
            end
            BRANCH: begin
                ctl.alusrca   = SRCA_RS1;
                ctl.alusrcb   = SRCB_RS2;
                ctl.aluop     = ALUOP_SUB;
                ctl.resultsrc = RES_ALUOUT;
                ctl.branch    = 1'b1;
                state_next    = FETCH;
            end
            JAL: begin
                ctl.alusrca   = SRCA_OLDPC;
                ctl.alusrcb   = SRCB_FOUR;
                ctl.resultsrc = RES_ALUOUT;
                ctl.pcupdate  = 1'b1;
                state_next    = ALUWB;
            end
            // Target goes straight to PC via the ALU result; ALUOut still holds
            // oldPC+4 from FETCH for the link write in JALRLINK.
            JALR: begin
                ctl.alusrca   = SRCA_RS1;
                ctl.alusrcb   = SRCB_IMM;
                ctl.immsrc    = IMM_I;
                ctl.resultsrc = RES_ALU;
                ctl.pcupdate  = 1'b1;
                state_next    = JALRLINK;
            end
`ifdef MAINDEC_UPIMM_EN
            LUI: begin
                ctl.alusrca = SRCA_ZERO;
                ctl.alusrcb = SRCB_IMM;
                ctl.immsrc  = IMM_U;
                state_next  = ALUWB;
            end
            AUIPC: begin
                ctl.alusrca = SRCA_OLDPC;
                ctl.alusrcb = SRCB_IMM;
                ctl.immsrc  = IMM_U;
                state_next  = ALUWB;
            end
`endif
            FAULT: begin
                ctl.fault = 1'b1;
            end
            default: state_next = FETCH;
        endcase
        if (expire) state_next = FAULT;
        if (i_rst)  ctl = '0;
    end

    assign o_mem_req   = ctl.mem_req;
    assign o_adrsrc    = ctl.adrsrc;
    assign o_irwrite   = ctl.irwrite;
    assign o_pcupdate  = ctl.pcupdate;
    assign o_branch    = ctl.branch;
    assign o_memwrite  = ctl.memwrite;
    assign o_regwrite  = ctl.regwrite;
    assign o_alusrca   = ctl.alusrca;
    assign o_alusrcb   = ctl.alusrcb;
    assign o_resultsrc = ctl.resultsrc;
    assign o_immsrc    = ctl.immsrc;
    assign o_aluop     = ctl.aluop;
    assign o_fault     = ctl.fault;

endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore control FSM that sequences each RV32I instruction over 3–5 cycles.
- Sits in the controller and drives the shared-memory, shared-ALU datapath.
- Adds four things the single-cycle decoder lacks:
  - a memory ready/request handshake with wait states;
  - a bus-timeout fault state;
  - JALR support;
  - optional LUI/AUIPC support.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory request may wait for i_mem_ready before fault; 0 disables timeout.
- TO_W, $clog2(MEM_TIMEOUT+1) (min 1): timeout counter width, derived; not overridden.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_op  in  7  opcode of the instruction register
- i_mem_ready  in  1  memory completes the current access this cycle
- o_mem_req  out  1  memory access active
- o_adrsrc  out  1  memory address: 0=PC, 1=ALU result reg
- o_irwrite  out  1  load instruction register
- o_pcupdate  out  1  unconditional PC write
- o_branch  out  1  branch cycle; PC write gated by zero flag outside
- o_memwrite  out  1  memory write enable
- o_regwrite  out  1  register file write
- o_alusrca  out  2  00=PC, 01=oldPC, 10=rs1
- o_alusrcb  out  2  00=rs2, 01=imm, 10=constant 4
- o_resultsrc  out  2  00=ALUOut, 01=data reg, 10=ALU result
- o_immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- o_aluop  out  2  00 add, 01 sub/branch, 10 funct-decoded
- o_fault  out  1  bus timeout, sticky

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous and active-high. Reset sets state=FETCH, counter=0, fault=0.
- Outputs during reset: while i_rst=1, all enables (irwrite, pcupdate, memwrite, regwrite, mem_req, branch) are forced 0 and multi-bit outputs are 0.
- Output style: outputs are combinational from state, gated by i_mem_ready where noted. Unlisted outputs are 0.
- FETCH:
  - Outputs: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite=pcupdate=i_mem_ready.
  - Next state: DECODE on ready, else stay.
- DECODE:
  - Outputs: alusrca=01, alusrcb=01, aluop=00; immsrc is set by i_op (computes branch/JAL target).
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - any other → FETCH (NOP, no writes)
- MEMADR: alusrca=10, alusrcb=01, aluop=00, immsrc=000 for a load or 001 for a store. Next state: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Next state: MEMWB on ready.
- MEMWB: resultsrc=01, regwrite=1. Next state: FETCH.
- MEMWRITE: mem_req=1, adrsrc=1, memwrite=i_mem_ready. Next state: FETCH on ready.
- EXECR: alusrca=10, alusrcb=00, aluop=10. Next state: ALUWB.
- EXECI: alusrca=10, alusrcb=01, immsrc=000, aluop=10. Next state: ALUWB.
- ALUWB: resultsrc=00, regwrite=1. Next state: FETCH.
- BRANCH: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1. Next state: FETCH.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1. Next state: ALUWB (rd=PC+4 written there).
- JALR:
  - Outputs: alusrca=10, alusrcb=01, immsrc=000, aluop=00, resultsrc=10, pcupdate=1.
  - Next state: JALRLINK.
  - Datapath contract: ALUOut holds oldPC+4 from FETCH and is not overwritten before JALRLINK, so the link value written there is oldPC+4.
- JALRLINK: resultsrc=00, regwrite=1. Next state: FETCH.
- Timeout:
  - The counter clears on entry to any mem_req state and increments each cycle that mem_req=1 and i_mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with ready still 0, the FSM goes to FAULT.
  - FAULT: o_fault=1, all enables 0, held until reset.
  - Ready asserted in the same cycle the limit is hit: ready wins; no fault.
- Latency: loads 5 cycles; stores, R, I and JALR 4 cycles; branch 3 cycles; each plus memory wait cycles.
- Reset mid-instruction: the next cycle is FETCH and no partial write occurs.

Optional Feature:
- Macro: MAINDEC_UPIMM_EN.
- Defined:
  - DECODE routes opcode 0110111 → LUI and 0010111 → AUIPC.
  - LUI: alusrca=11 (zero source), alusrcb=01, immsrc=100, aluop=00. Next state: ALUWB.
  - AUIPC: alusrca=01, alusrcb=01, immsrc=100, aluop=00. Next state: ALUWB.
- Undefined: both opcodes are treated as NOP (DECODE → FETCH), and alusrca=11 is never driven.

Decomposition:
- Shared package (maindec_pkg):
  - state enum statetype_e;
  - opcode localparams OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - encodings IMM_I/S/B/J/U, ALUOP_ADD/SUB/FUNCT, SRCA_*, SRCB_*, RES_*.
- Sub-module: mem_timeout_counter (clear/increment/expire), instantiated once.
- State register, next-state logic and output logic stay in the top module.

Test Plan:
- Reset, then op=0000011 with ready always 1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; regwrite=1 only in cycle 5, with resultsrc=01.
- op=0100011 with ready low for 3 cycles in MEMWRITE: memwrite=0 for 3 cycles, then 1 for exactly one cycle, then FETCH; no fault.
- MEM_TIMEOUT=4 and ready held 0 in FETCH: after 4 wait cycles state=FAULT and o_fault=1 persists; i_rst=1 for one cycle returns FETCH with fault=0.
- op=1100111 (JALR): pcupdate=1 in JALR state with alusrca=10 and alusrcb=01; next cycle regwrite=1 with resultsrc=00; back to FETCH at cycle 5.
- op=0110111 with MAINDEC_UPIMM_EN: LUI state drives immsrc=100 and alusrca=11, then ALUWB writes. Without the macro: DECODE → FETCH with no regwrite.
- i_rst asserted during EXECR with op=0110011: the next cycle is FETCH and regwrite stays 0 throughout.
